// File: rtl/hs4_pkg.sv
// Shared types and limits for the 4-phase bundled-data receiver.
package hs4_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        ACK_HI   = 2'd2
    } hs4_state_e;

    localparam int HS4_MIN_SYNC_STAGES = 2;
    localparam int HS4_MIN_DEPTH       = 2;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchroniser with a selectable reset value.
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hs4_rx_sync.sv
// Clocked receiver for the 4-phase bundled-data handshake, feeding a valid/ready FIFO.
// Optional HS4_RX_SYNC_XFER_CNT_EN adds xfer_cnt and stall_cnt statistics outputs.
module hs4_rx_sync
    import hs4_pkg::*;
#(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [DW-1:0]          data_in,
    output logic                   ack,
    output logic [DW-1:0]          out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef HS4_RX_SYNC_XFER_CNT_EN
    ,
    output logic [15:0]            xfer_cnt,
    output logic [15:0]            stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    if (SYNC_STAGES < HS4_MIN_SYNC_STAGES) begin : g_bad_sync
        $error("hs4_rx_sync: SYNC_STAGES too small");
    end
    if (DEPTH < HS4_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hs4_rx_sync: DEPTH must be a power of two >= 2");
    end

    logic req_s;

    // Reset to 1 so a request held high through reset looks "already seen".
    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req),
        .q   (req_s)
    );

    hs4_state_e     state_q, state_d;
    logic           ack_q, ack_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    level_q, level_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic [DW-1:0]  mem_q [DEPTH];

    logic full;
    logic push;
    logic pop;
    logic stall;

    assign full = (level_q == LVL_FULL);
    assign pop  = (level_q != '0) && out_ready;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        stall   = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (!req_s) state_d = IDLE;
            end
            IDLE: begin
                if (req_s && !full) begin
                    push    = 1'b1;
                    state_d = ACK_HI;
                end else if (req_s) begin
                    stall = 1'b1;
                end
            end
            ACK_HI: begin
                if (!req_s) state_d = IDLE;
            end
            default: state_d = WAIT_LOW;
        endcase
        ack_d = (state_d == ACK_HI);
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        out_data_d = out_data_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
        // Keep the registered head word equal to mem[rd_ptr] whenever non-empty.
        if (pop) begin
            if (level_q > (AW + 1)'(1)) begin
                out_data_d = mem_q[rd_ptr_q + AW'(1)];
            end else if (push) begin
                out_data_d = data_in;
            end
        end else if (push && level_q == '0) begin
            out_data_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_LOW;
            ack_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    assign ack        = ack_q;
    assign out_data   = out_data_q;
    assign out_valid  = (level_q != '0);
    assign fifo_level = level_q;

`ifdef HS4_RX_SYNC_XFER_CNT_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        xfer_cnt_d  = xfer_cnt_q + 16'(push);
        stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign xfer_cnt  = xfer_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hs4_rx_sync.sv
// Directed bench for hs4_rx_sync: latency, backpressure, push/pop overlap, reset, wrap.
module tb_hs4_rx_sync;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int SYNC_STAGES = 2;
    localparam int HS_LAT = SYNC_STAGES + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [DW-1:0] data_in;
    logic          ack;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    fifo_level;
`ifdef HS4_RX_SYNC_XFER_CNT_EN
    logic [15:0]   xfer_cnt;
    logic [15:0]   stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hs4_rx_sync #(
        .DW          (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level)
`ifdef HS4_RX_SYNC_XFER_CNT_EN
        ,
        .xfer_cnt   (xfer_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset(input bit check_vals);
        rst = 1'b1;
        req = 1'b0;
        out_ready = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (check_vals) begin
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_level", 32'(fifo_level), 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    // Full 4-phase handshake, starting and ending at a negedge.
    task automatic hs(input logic [7:0] d, input bit chk_out, output int edges_up);
        int n;
        data_in = d;
        req = 1'b1;
        edges_up = 0;
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (ack) break;
        end
        edges_up = n;
        if (!ack) chk("hs_ack_rise_timeout", 32'd0, 32'd1);
        if (chk_out) chk("hs_out_data", 32'(out_data), 32'(d));
        req = 1'b0;
        n = 0;
        while (ack && n < 60) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (ack) chk("hs_ack_fall_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int e;
        do_reset(1'b1);

        // Basic transfer with exact latency.
        out_ready = 1'b1;
        data_in = 8'hA5;
        req = 1'b1;
        repeat (HS_LAT - 1) @(posedge clk);
        @(negedge clk);
        chk("basic_ack_early", 32'(ack), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("basic_ack_rise", 32'(ack), 32'd1);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_data", 32'(out_data), 32'hA5);
        req = 1'b0;
        repeat (HS_LAT - 1) @(posedge clk);
        @(negedge clk);
        chk("basic_ack_hold", 32'(ack), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("basic_ack_fall", 32'(ack), 32'd0);
        chk("basic_empty", 32'(out_valid), 32'd0);
        chk("basic_data_hold", 32'(out_data), 32'hA5);

        // Backpressure: fill, stall the fifth word, release with one pop.
        do_reset(1'b0);
        for (int i = 1; i <= 4; i++) hs(8'(i), 1'b0, e);
        chk("bp_level_full", 32'(fifo_level), 32'd4);
        data_in = 8'h05;
        req = 1'b1;
        e = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            e++;
            chk("bp_ack_stalled", 32'(ack), 32'd0);
        end
        chk("bp_head_01", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e++;
        out_ready = 1'b0;
        chk("bp_level_after_pop", 32'(fifo_level), 32'd3);
        chk("bp_ack_not_yet", 32'(ack), 32'd0);
        for (int n = 0; n < 20 && !ack; n++) begin
            @(posedge clk);
            @(negedge clk);
            e++;
        end
        chk("bp_ack_rise", 32'(ack), 32'd1);
        chk("bp_edges_to_ack", 32'(e), 32'd8);
        chk("bp_level_refill", 32'(fifo_level), 32'd4);
`ifdef HS4_RX_SYNC_XFER_CNT_EN
        chk("bp_xfer_cnt", 32'(xfer_cnt), 32'd5);
        chk("bp_stall_cnt", 32'(stall_cnt), 32'(e - HS_LAT));
`endif
        req = 1'b0;
        for (int n = 0; n < 20 && ack; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_ack_fall", 32'(ack), 32'd0);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("bp_drain_valid", 32'(out_valid), 32'd1);
            chk("bp_drain_data", 32'(out_data), 32'(i));
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Push and pop on the same edge with two words queued.
        do_reset(1'b0);
        hs(8'h21, 1'b0, e);
        hs(8'h22, 1'b0, e);
        chk("pp_level2", 32'(fifo_level), 32'd2);
        data_in = 8'h23;
        req = 1'b1;
        repeat (HS_LAT - 1) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("pp_ack", 32'(ack), 32'd1);
        chk("pp_level_same", 32'(fifo_level), 32'd2);
        chk("pp_head", 32'(out_data), 32'h22);
        req = 1'b0;
        for (int n = 0; n < 20 && ack; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pp_tail", 32'(out_data), 32'h23);
        @(posedge clk);
        @(negedge clk);
        chk("pp_empty", 32'(out_valid), 32'd0);

        // Reset while in ACK_HI with req held high.
        do_reset(1'b0);
        data_in = 8'h77;
        req = 1'b1;
        for (int n = 0; n < 20 && !ack; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mr_in_ack_hi", 32'(ack), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mr_ack_drop", 32'(ack), 32'd0);
        chk("mr_valid_drop", 32'(out_valid), 32'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("mr_no_repush_ack", 32'(ack), 32'd0);
        chk("mr_no_repush_level", 32'(fifo_level), 32'd0);
        req = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        hs(8'h3C, 1'b0, e);
        chk("mr_single_push", 32'(fifo_level), 32'd1);
        chk("mr_data", 32'(out_data), 32'h3C);

        // Ten transfers through the pointer wrap.
        do_reset(1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) hs(8'(8'h10 + i), 1'b1, e);
        chk("wrap_empty", 32'(fifo_level), 32'd0);
        chk("wrap_last", 32'(out_data), 32'h19);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hs4_rx_sync.md
Name: hs4_rx_sync

Overview:
- Clocked receiving end of the 4-phase (return-to-zero) bundled-data handshake used by our self-timed blocks (C-element/mutex pipelines).
- Synchronises the asynchronous request and captures the bundled data into a small FIFO.
- Acknowledges the async sender and presents the words to a synchronous valid/ready consumer.
- Sits at every async-to-clocked boundary.

Parameters:
- DW, 8, bundled data width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, request synchroniser flops; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- req  input  1  async 4-phase request from sender.
- data_in  input  DW  bundled data; stable from req rise until ack rise.
- ack  output  1  4-phase acknowledge to sender; registered.
- out_data  output  DW  FIFO head word.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- fifo_level  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All flops update on posedge clk.
- Values during reset: ack=0, out_valid=0, fifo_level=0, out_data=0, FSM in WAIT_LOW.
- Synchroniser reset value: all SYNC_STAGES flops reset to 1, not 0. req_s is the last stage.
- FSM states:
  - WAIT_LOW: ack=0. Go to IDLE when req_s==0. Prevents a request still high across reset from being accepted twice.
  - IDLE: ack=0. If req_s==1 and fifo_level<DEPTH: push data_in and go to ACK_HI. If the FIFO is full, stay in IDLE with ack=0 (backpressure to the sender).
  - ACK_HI: ack=1. Go to IDLE with ack=0 when req_s==0.
- Latency:
  - req rise to ack rise: SYNC_STAGES+1 clk edges when the FIFO is not full.
  - req fall to ack fall: SYNC_STAGES+1 edges.
  - Push to out_valid high: 1 edge.
- Data capture:
  - data_in is sampled directly, with no synchroniser, at the push edge.
  - The bundling constraint is met because the synchroniser delay exceeds the data skew.
- FIFO:
  - Circular buffer, pointers of width $clog2(DEPTH) that wrap at DEPTH.
  - Pop when out_valid && out_ready; out_data is the head word (registered array read).
  - Simultaneous push and pop: both occur and fifo_level is unchanged.
  - Full test uses the registered level. When full, a same-cycle pop does not enable a push; the push happens next cycle.
  - Pop when empty: ignored.
  - out_data holds its last value when empty.
- Reset mid-transfer (e.g. in ACK_HI):
  - ack drops the cycle after reset and FIFO contents are discarded.
  - The FSM waits in WAIT_LOW for req to return low before accepting again.
- Protocol violation: req falling while in IDLE (no ack yet) is ignored. The FSM waits for the next req_s rise.

Optional Feature:
- Macro HS4_RX_SYNC_XFER_CNT_EN.
- When defined:
  - Extra output xfer_cnt, 16 bits, counts accepted pushes and wraps 0xFFFF->0.
  - Extra output stall_cnt, 16 bits, counts cycles in IDLE with req_s==1 and the FIFO full; saturates at 0xFFFF.
  - Both counters clear on rst.
- When undefined: neither port nor its logic exists; behaviour is otherwise identical.

Decomposition:
- Package hs4_pkg holds:
  - State enum (WAIT_LOW=2'd0, IDLE=2'd1, ACK_HI=2'd2).
  - Localparams for the minimum SYNC_STAGES and DEPTH.
- Sub-module sync_bit, a SYNC_STAGES-flop synchroniser with a RST_VAL parameter. Instantiated once here with RST_VAL=1; reusable elsewhere.
- FIFO stays inline.

Test Plan:
- Basic transfer: after reset release, drive req=0 then req=1 with data_in=8'hA5, out_ready=1.
  - ack rises 3 edges later (SYNC_STAGES=2) and out_data=8'hA5 with out_valid=1.
  - Drop req: ack falls 3 edges later.
- Backpressure: out_ready=0, four handshakes with 8'h01..8'h04.
  - fifo_level reaches 4.
  - A fifth req=1 with 8'h05 leaves ack=0.
  - One pop (out_ready=1 for one cycle) leads to ack rising and 8'h05 being stored.
  - Drain order is 01,02,03,04,05.
- Simultaneous push/pop: FIFO holding 2 words, pop on the same edge as a push; fifo_level stays 2.
- Reset mid-operation:
  - Assert rst while in ACK_HI with req=1: ack=0 and out_valid=0 the next cycle.
  - With req still 1 after reset, no push occurs.
  - req=0 then req=1 with 8'h3C: a single push.
- Wrap-around: 10 consecutive transfers 8'h10..8'h19 with out_ready=1; output order is preserved across the pointer wrap.
- With HS4_RX_SYNC_XFER_CNT_EN defined, rerun the backpressure test:
  - xfer_cnt=5.
  - stall_cnt equals the number of full-stall cycles measured by the bench.
